// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: sweep codes, sweep length and FSM state type shared by run_ctrl.
package run_ctrl_pkg;
   localparam logic [3:0] ST_IDLE = 4'd0;
   localparam logic [3:0] ST_FWD = 4'd1;
   localparam logic [3:0] ST_REV = 4'd2;
   localparam int STEPS_PER_RUN = 4;
   typedef enum logic [1:0] {S_IDLE, S_FWD, S_REV, S_BEEP} fsm_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability debouncer and rising-edge press pulse.
module btn_debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);
   localparam int CW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
   logic [1:0] sync;
   logic [CW-1:0] cnt;
   logic level, level_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= '0;
         cnt <= '0;
         level <= 1'b0;
         level_q <= 1'b0;
         press <= 1'b0;
      end else begin
         sync <= {sync[0], btn};
         level_q <= level;
         press <= level & ~level_q;
         // any sample matching the current level restarts the stability count
         if (sync[1] == level) cnt <= '0;
         else if (cnt == CW'(DB_CYCLES - 1)) begin
            level <= sync[1];
            cnt <= '0;
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: button front end, idle/forward/reverse/beep FSM, step divider and buzzer tone.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int STEP_DIV = 47_000_000,
   parameter int DB_CYCLES = 1_000_000,
   parameter int BUZZ_CYCLES = 25_000_000,
   parameter int TONE_DIV = 25_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_fwd,
   input  logic       btn_rev,
   input  logic       btn_run,
   output logic [3:0] state,
   output logic       step,
   output logic       run_en,
   output logic       buzzer
);
   localparam int DW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
   localparam int BW = BUZZ_CYCLES > 1 ? $clog2(BUZZ_CYCLES) : 1;
   localparam int TW = TONE_DIV > 1 ? $clog2(TONE_DIV) : 1;
   fsm_t fsm, fsm_nx;
   logic p_fwd, p_rev, p_run;
   logic [DW-1:0] div;
   logic [1:0] step_cnt;
   logic [BW-1:0] dur;
   logic [TW-1:0] tone;
   logic sweeping, adv, tc, dur_end, tone_end;
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_fwd (.clk(clk), .reset(reset), .btn(btn_fwd), .press(p_fwd));
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_rev (.clk(clk), .reset(reset), .btn(btn_rev), .press(p_rev));
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_run (.clk(clk), .reset(reset), .btn(btn_run), .press(p_run));
   always_ff @(posedge clk) begin
      if (reset) fsm <= S_IDLE;
      else fsm <= fsm_nx;
   end
   always_comb begin
      sweeping = fsm == S_FWD || fsm == S_REV;
      adv = sweeping & run_en & ~p_run;
      tc = div == DW'(STEP_DIV - 1);
      dur_end = dur == BW'(BUZZ_CYCLES - 1);
      tone_end = tone == TW'(TONE_DIV - 1);
      // the 2-bit step count wraps to zero on the last step of a sweep
      fsm_nx = fsm == S_IDLE ? (p_fwd & ~p_rev ? S_FWD : p_rev & ~p_fwd ? S_REV : S_IDLE)
             : fsm == S_BEEP ? (dur_end ? S_IDLE : S_BEEP)
             : (step && step_cnt == 2'(STEPS_PER_RUN % 4)) ? S_BEEP : fsm;
      state = fsm == S_FWD ? ST_FWD : fsm == S_REV ? ST_REV : ST_IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         div <= '0;
         step_cnt <= '0;
         dur <= '0;
         tone <= '0;
         step <= 1'b0;
         run_en <= 1'b1;
         buzzer <= 1'b0;
      end else begin
         run_en <= run_en ^ p_run;
         step <= adv & tc;
         if (fsm == S_IDLE) begin
            div <= '0;
            step_cnt <= '0;
         end else if (adv) begin
            div <= tc ? '0 : div + 1'b1;
            step_cnt <= step_cnt + {1'b0, tc};
         end
         if (fsm != S_BEEP && fsm_nx == S_BEEP) begin
            buzzer <= 1'b1;
            tone <= '0;
            dur <= '0;
         end else if (fsm == S_BEEP) begin
            dur <= dur_end ? '0 : dur + 1'b1;
            tone <= tone_end ? '0 : tone + 1'b1;
            buzzer <= dur_end ? 1'b0 : buzzer ^ tone_end;
         end
      end
   end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed scenarios against a cycle-level behavioural model plus literal timing checks.
module tb_run_ctrl;
   localparam int SD = 10, DB = 4, BZ = 20, TD = 2, N = 8192;
   logic clk = 1'b0, reset = 1'b1, btn_fwd = 1'b0, btn_rev = 1'b0, btn_run = 1'b0;
   logic [3:0] state;
   logic step, run_en, buzzer;
   int vectors = 0, miscompares = 0, cyc = 0, steps_seen = 0;
   bit h[3][N];
   bit mdb[3], mdb_q[3], mpress[3];
   int mmode = 0, act = 0, nst = 0, bi = 0;
   bit mrun = 1'b1, mstep = 1'b0, mbuz = 1'b0, mvalid = 1'b0;

   run_ctrl #(.STEP_DIV(SD), .DB_CYCLES(DB), .BUZZ_CYCLES(BZ), .TONE_DIV(TD)) dut (
      .clk(clk), .reset(reset), .btn_fwd(btn_fwd), .btn_rev(btn_rev), .btn_run(btn_run),
      .state(state), .step(step), .run_en(run_en), .buzzer(buzzer));

   always #5 clk = ~clk;

   // model: a debounced level flips once the synchronized raw level has differed for DB cycles
   always @(posedge clk) begin
      bit raw[3];
      bit ndb[3];
      bit np[3];
      bit all;
      int nmode;
      bit nstep, nbuz;
      raw = '{btn_fwd, btn_rev, btn_run};
      if (reset) begin
         for (int b = 0; b < 3; b++) begin
            h[b][cyc] = 1'b0;
            if (cyc > 0) h[b][cyc-1] = 1'b0;
            mdb[b] = 1'b0;
            mdb_q[b] = 1'b0;
            mpress[b] = 1'b0;
         end
         mmode = 0; mrun = 1'b1; mstep = 1'b0; mbuz = 1'b0; act = 0; nst = 0; bi = 0;
         mvalid = 1'b1;
      end else if (mvalid) begin
         nmode = mmode;
         nstep = 1'b0;
         nbuz = mbuz;
         case (mmode)
            0: begin
               nbuz = 1'b0;
               if (mpress[0] && !mpress[1]) begin nmode = 1; act = 0; nst = 0; end
               else if (mpress[1] && !mpress[0]) begin nmode = 2; act = 0; nst = 0; end
            end
            1, 2: begin
               if (mstep && nst == 4) begin nmode = 3; bi = 0; nbuz = 1'b1; end
               else if (mrun && !mpress[2]) begin
                  act++;
                  if (act % SD == 0) begin nstep = 1'b1; nst++; end
               end
            end
            default: begin
               bi++;
               if (bi == BZ) begin nmode = 0; nbuz = 1'b0; end
               else nbuz = ((bi / TD) % 2) == 0;
            end
         endcase
         mrun = mrun ^ mpress[2];
         mmode = nmode;
         mstep = nstep;
         mbuz = nbuz;
         for (int b = 0; b < 3; b++) begin
            h[b][cyc] = raw[b];
            all = 1'b1;
            for (int k = 0; k < DB; k++)
               if ((cyc - k - 2 < 0 ? 1'b0 : h[b][cyc-k-2]) == mdb[b]) all = 1'b0;
            ndb[b] = all ? ~mdb[b] : mdb[b];
            np[b] = mdb[b] & ~mdb_q[b];
            mdb_q[b] = mdb[b];
            mdb[b] = ndb[b];
            mpress[b] = np[b];
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      logic [3:0] es;
      if (mvalid) begin
         es = mmode == 1 ? 4'd1 : mmode == 2 ? 4'd2 : 4'd0;
         vectors++;
         if ({state, step, run_en, buzzer} !== {es, mstep, mrun, mbuz}) begin
            miscompares++;
            $display("FAIL model cyc %0d: got state=%0d step=%b run_en=%b buzzer=%b, want state=%0d step=%b run_en=%b buzzer=%b",
                     cyc, state, step, run_en, buzzer, es, mstep, mrun, mbuz);
         end
         if (step === 1'b1) steps_seen++;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at cyc %0d: got %0d, want %0d", name, cyc, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_to(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   initial begin
      int t, s0;
      tick(3);
      reset = 1'b0;
      chk("rst_state", state, 0);
      chk("rst_step", step, 0);
      chk("rst_run_en", run_en, 1);
      chk("rst_buzzer", buzzer, 0);
      tick(50);
      chk("idle_steps", steps_seen, 0);
      chk("idle_state", state, 0);

      // clean forward sweep
      btn_fwd = 1'b1; t = cyc; s0 = steps_seen;
      wait_to(t + 7); chk("fwd_pre", state, 0);
      wait_to(t + 8); chk("fwd_state", state, 1); btn_fwd = 1'b0;
      wait_to(t + 17); chk("fwd_step1_pre", step, 0);
      wait_to(t + 18); chk("fwd_step1", step, 1);
      wait_to(t + 48); chk("fwd_step4", step, 1);
      wait_to(t + 49); chk("fwd_beep_state", state, 0); chk("fwd_buz_on", buzzer, 1);
      chk("fwd_steps", steps_seen - s0, 4);
      wait_to(t + 51); chk("fwd_buz_tog", buzzer, 0);
      wait_to(t + 65); chk("fwd_buz_late", buzzer, 1);
      wait_to(t + 69); chk("fwd_buz_end", buzzer, 0); chk("fwd_idle", state, 0);
      tick(5);

      // bounced reverse press, plus ignored re-press mid sweep
      btn_rev = 1'b1; tick(2); btn_rev = 1'b0; tick(2); btn_rev = 1'b1;
      t = cyc; s0 = steps_seen;
      wait_to(t + 7); chk("rev_pre", state, 0);
      wait_to(t + 8); chk("rev_state", state, 2);
      wait_to(t + 12); btn_rev = 1'b0;
      wait_to(t + 20); btn_rev = 1'b1;
      wait_to(t + 28); btn_rev = 1'b0;
      wait_to(t + 40); chk("rev_still", state, 2);
      wait_to(t + 49); chk("rev_beep", state, 0); chk("rev_steps", steps_seen - s0, 4);
      wait_to(t + 75); chk("rev_once", steps_seen - s0, 4);

      // pause and resume
      btn_fwd = 1'b1; t = cyc; s0 = steps_seen;
      wait_to(t + 8); btn_fwd = 1'b0;
      wait_to(t + 19); chk("pz_step1", steps_seen - s0, 1); btn_run = 1'b1;
      wait_to(t + 26); chk("pz_run_hi", run_en, 1);
      wait_to(t + 27); chk("pz_run_lo", run_en, 0); btn_run = 1'b0;
      wait_to(t + 57); btn_run = 1'b1;
      wait_to(t + 64); chk("pz_still_lo", run_en, 0); chk("pz_frozen", steps_seen - s0, 1);
      wait_to(t + 65); chk("pz_run_back", run_en, 1); btn_run = 1'b0;
      wait_to(t + 67); chk("pz_step2", step, 1);
      wait_to(t + 88); chk("pz_beep", state, 0); chk("pz_steps", steps_seen - s0, 4);
      wait_to(t + 115);

      // simultaneous fwd + rev from idle
      btn_fwd = 1'b1; btn_rev = 1'b1; t = cyc; s0 = steps_seen;
      wait_to(t + 8); chk("sim_state", state, 0); btn_fwd = 1'b0; btn_rev = 1'b0;
      wait_to(t + 40); chk("sim_steps", steps_seen - s0, 0); chk("sim_state2", state, 0);

      // reset between 2nd and 3rd step
      btn_fwd = 1'b1; t = cyc;
      wait_to(t + 8); btn_fwd = 1'b0;
      wait_to(t + 31); chk("rs1_mid", state, 1); reset = 1'b1;
      wait_to(t + 32); reset = 1'b0;
      chk("rs1_state", state, 0); chk("rs1_buz", buzzer, 0); chk("rs1_run", run_en, 1);
      tick(10);

      // reset during beep, with run toggled off inside the beep
      btn_fwd = 1'b1; t = cyc;
      wait_to(t + 8); btn_fwd = 1'b0;
      wait_to(t + 42); btn_run = 1'b1;
      wait_to(t + 49); btn_run = 1'b0;
      wait_to(t + 53); chk("rs2_run_off", run_en, 0); chk("rs2_buz", buzzer, 1);
      wait_to(t + 55); reset = 1'b1;
      wait_to(t + 56); reset = 1'b0;
      chk("rs2_state", state, 0); chk("rs2_buz0", buzzer, 0); chk("rs2_run", run_en, 1);
      tick(10);

      // fresh sweep after resets
      btn_fwd = 1'b1; t = cyc; s0 = steps_seen;
      wait_to(t + 8); chk("fr_state", state, 1); btn_fwd = 1'b0;
      wait_to(t + 49); chk("fr_beep", state, 0); chk("fr_steps", steps_seen - s0, 4);
      wait_to(t + 75); chk("fr_idle_buz", buzzer, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/run_ctrl.md
# run_ctrl

Control stage directly upstream of the LED sweep stage. Debounces the three board push-buttons, runs the idle/forward/reverse sweep state machine, and generates the ~0.94 s step enable that advances the LED pattern. Sounds the buzzer when a 4-step sweep completes. Drives the downstream `state`, step and start/stop inputs from the 50 MHz system clock.

## Interface
- STEP_DIV, 47_000_000: clk cycles per step pulse (0.94 s at 50 MHz).
- DB_CYCLES, 1_000_000: cycles a synchronized button must hold a new level before the debounced level changes (20 ms).
- BUZZ_CYCLES, 25_000_000: buzzer-on duration after a sweep (0.5 s).
- TONE_DIV, 25_000: buzzer square-wave half period in cycles (1 kHz).
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- btn_fwd  in  1  raw asynchronous button, active-high; requests a forward sweep.
- btn_rev  in  1  raw asynchronous button, active-high; requests a reverse sweep.
- btn_run  in  1  raw asynchronous button, active-high; toggles run/pause.
- state  out  4  sweep code to the LED stage: 0 idle, 1 forward, 2 reverse.
- step  out  1  one-cycle pulse; the LED stage advances one position per pulse.
- run_en  out  1  start/stop level to the LED stage; 1 = running.
- buzzer  out  1  buzzer drive, square wave while beeping.

## Operation
- Each button: 2-flop synchronizer, then debouncer, then rising-edge detector producing a one-cycle press pulse.
- FSM states IDLE, FWD, REV, BEEP. `state` = 1 in FWD, 2 in REV, 0 in IDLE and BEEP.
- IDLE: fwd press goes to FWD; rev press goes to REV. Fwd and rev pressed in the same cycle are ignored; FSM stays in IDLE. Entering FWD/REV clears the divider and the step count.
- FWD/REV: the divider counts 0..STEP_DIV-1. At terminal count it emits `step` and wraps to 0. The step counter (2 bits) increments per step. On the 4th step, go to BEEP the following cycle.
- Direction presses while in FWD, REV or BEEP are ignored (no reversal, no restart).
- Run press toggles `run_en` in any state. While `run_en`=0, the divider and step count freeze and `step` is held at 0. Resuming continues from the frozen count.
- BEEP: the tone counter toggles `buzzer` every TONE_DIV cycles. The duration counter runs BUZZ_CYCLES cycles, then the FSM goes to IDLE with `buzzer`=0. BEEP is not paused by `run_en`.
- Counter widths: `$clog2` of the respective parameter. No counter exceeds parameter-1.

## Timing
- Reset values: `state`=0, `step`=0, `run_en`=1, `buzzer`=0. FSM is IDLE and all counters and debounced levels are 0.
- Reset asserted mid-sweep or mid-beep returns to IDLE on the next edge. No step pulse or buzzer toggle occurs in that cycle.
- Button latency: a clean raw level change at cycle t gives a press pulse at t+2+DB_CYCLES+1. A bounce shorter than DB_CYCLES restarts the stability count and produces no pulse.
- The FSM registers its transition on the press-pulse edge. `state` is valid 1 cycle after the press pulse.
- First `step` fires STEP_DIV cycles after `state` becomes nonzero. Subsequent steps are spaced STEP_DIV apart (plus any paused cycles).
- `state` drops to 0 and `buzzer` starts 1 cycle after the 4th step.
- A run press arriving in the same cycle as divider terminal count takes priority: no step is emitted and the count holds.

## Structure
- Package `run_ctrl_pkg`:
  - state codes ST_IDLE=4'd0, ST_FWD=4'd1, ST_REV=4'd2;
  - STEPS_PER_RUN=4;
  - FSM state enum.
- Sub-module `btn_debounce` (synchronizer, debounce counter, edge pulse; parameter DB_CYCLES), instantiated three times.
- FSM, step divider and buzzer generator stay in `run_ctrl`.

## Test plan
All scenarios use STEP_DIV=10, DB_CYCLES=4, BUZZ_CYCLES=20, TONE_DIV=2.
- Reset then idle 50 cycles -> `state`=0, `run_en`=1, `step`=0, `buzzer`=0 throughout.
- Clean fwd press -> `state`=1 at press+8. Four `step` pulses 10 cycles apart, then `state`=0, `buzzer` toggling every 2 cycles for 20 cycles, then 0.
- Rev press with a 2-cycle bounce before a stable level -> exactly one sweep with `state`=2. Rev press again during the sweep -> ignored, still exactly 4 steps.
- Fwd sweep, run press after 1st step, hold 30 cycles, run press again -> `run_en` 1→0→1. No steps while paused. Remaining 3 steps occur, total 4.
- Fwd and rev pressed simultaneously from IDLE -> `state` stays 0 and no step occurs.
- Reset asserted between 2nd and 3rd step, and again during BEEP -> `state`=0, `buzzer`=0, `run_en`=1 next cycle. Next fwd press starts a fresh 4-step sweep.
